lpc_watchdog_timer: RTL and testbench

- System watchdog timer, directly downstream of the LPC register block.
- Consumes the LPC-programmed Watch Dog register and the load strobe, counts down in 100 ms ticks, and raises a pre-timeout interrupt request.
- On expiry it raises a system reset request pulse.
- Its WatchDogIREQ/WatchDogOccurred outputs feed back into the LPC block as read/interrupt status.

---
 rtl/lpc_watchdog_timer.sv | 135 +++++++++++++
 tb/tb_lpc_watchdog_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_watchdog_timer.sv
// LPC system watchdog: counts down in prescaled ticks, raises a pre-timeout IREQ,
// then a fixed-width reset request pulse on expiry.
module lpc_watchdog_timer #(
  parameter int unsigned TICK_DIV  = 3300000,
  parameter int unsigned PRE_TICKS = 2,
  parameter int unsigned RST_PULSE = 16
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic [7:0] WatchDogReg,
  input  logic       LoadWDTimer,
  input  logic       ClrWDIreq,
  input  logic       ClrWDOccurred,
  output logic       WatchDogIREQ,
  output logic       WatchDogOccurred,
  output logic       WDResetReq,
  output logic [6:0] WDCount,
  output logic [1:0] WDState
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [6:0]    PRE_LIM    = 7'(PRE_TICKS);
  localparam logic [7:0]    PULSE_LAST = 8'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PRE  = 2'd2,
    ST_FIRE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pulse_q, pulse_d;
  logic          load_pend_q;
  logic          ireq_q, ireq_d;
  logic          occ_q, occ_d;
  logic          rst_req_q, rst_req_d;

  logic          armed;
  logic          tick;
  logic          ireq_set;
  logic          occ_set;
  logic [6:0]    reload_val;

  assign armed      = (state_q == ST_RUN) || (state_q == ST_PRE);
  assign tick       = armed && (presc_q == PRESC_MAX);
  assign reload_val = (WatchDogReg[5:0] == 6'd0) ? 7'd64 : {1'b0, WatchDogReg[5:0]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    pulse_d   = pulse_q;
    rst_req_d = rst_req_q;
    ireq_set  = 1'b0;
    occ_set   = 1'b0;

    if (state_q == ST_FIRE) begin
      // Reloads and disables are deliberately ignored until the pulse completes.
      if (pulse_q == 8'd0) begin
        state_d   = ST_IDLE;
        rst_req_d = 1'b0;
      end else begin
        pulse_d = pulse_q - 8'd1;
      end
    end else if (load_pend_q) begin
      presc_d = '0;
      if (WatchDogReg[7]) begin
        state_d = ST_RUN;
        count_d = reload_val;
      end else begin
        state_d = ST_IDLE;
        count_d = 7'd0;
      end
    end else if (armed) begin
      if (!WatchDogReg[7]) begin
        state_d = ST_IDLE;
        count_d = 7'd0;
        presc_d = '0;
      end else if (tick && (count_q == 7'd1)) begin
        state_d   = ST_FIRE;
        count_d   = 7'd0;
        presc_d   = '0;
        pulse_d   = PULSE_LAST;
        rst_req_d = 1'b1;
        occ_set   = 1'b1;
      end else begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          count_d = count_q - 7'd1;
        end
        if ((state_q == ST_RUN) && WatchDogReg[6] && (count_q <= PRE_LIM)) begin
          state_d  = ST_PRE;
          ireq_set = 1'b1;
        end
      end
    end

    // A set on the same cycle as a clear strobe must win.
    ireq_d = ireq_set | (ireq_q & ~ClrWDIreq);
    occ_d  = occ_set  | (occ_q  & ~ClrWDOccurred);
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q     <= ST_IDLE;
      count_q     <= 7'd0;
      presc_q     <= '0;
      pulse_q     <= 8'd0;
      load_pend_q <= 1'b0;
      ireq_q      <= 1'b0;
      occ_q       <= 1'b0;
      rst_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      pulse_q     <= pulse_d;
      load_pend_q <= LoadWDTimer;
      ireq_q      <= ireq_d;
      occ_q       <= occ_d;
      rst_req_q   <= rst_req_d;
    end
  end

  assign WatchDogIREQ     = ireq_q;
  assign WatchDogOccurred = occ_q;
  assign WDResetReq       = rst_req_q;
  assign WDCount          = count_q;
  assign WDState          = state_q;

endmodule

// File: tb/tb_lpc_watchdog_timer.sv
// Directed plus randomized checks of lpc_watchdog_timer against a behavioural model.
module tb_lpc_watchdog_timer;

  localparam int TICK_DIV  = 4;
  localparam int PRE_TICKS = 2;
  localparam int RST_PULSE = 3;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b0;
  logic [7:0] wd_reg = 8'h00;
  logic       LoadWDTimer = 1'b0;
  logic       ClrWDIreq = 1'b0;
  logic       ClrWDOccurred = 1'b0;
  logic       WatchDogIREQ;
  logic       WatchDogOccurred;
  logic       WDResetReq;
  logic [6:0] WDCount;
  logic [1:0] WDState;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=idle 1=run 2=pre 3=fire; phase = cycles into current tick period.
  int m_mode, m_count, m_phase, m_fire_left;
  bit m_pend, m_ireq, m_occ, m_rreq;

  lpc_watchdog_timer #(
    .TICK_DIV (TICK_DIV),
    .PRE_TICKS(PRE_TICKS),
    .RST_PULSE(RST_PULSE)
  ) dut (
    .LpcClock        (LpcClock),
    .PciReset        (PciReset),
    .WatchDogReg     (wd_reg),
    .LoadWDTimer     (LoadWDTimer),
    .ClrWDIreq       (ClrWDIreq),
    .ClrWDOccurred   (ClrWDOccurred),
    .WatchDogIREQ    (WatchDogIREQ),
    .WatchDogOccurred(WatchDogOccurred),
    .WDResetReq      (WDResetReq),
    .WDCount         (WDCount),
    .WDState         (WDState)
  );

  always #5 LpcClock = ~LpcClock;

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_phase = 0; m_fire_left = 0;
    m_pend = 0; m_ireq = 0; m_occ = 0; m_rreq = 0;
  endtask

  // One clock edge of the watchdog rules, applied to inputs seen at that edge.
  task automatic model_edge(input bit ld, input bit ci, input bit co, input logic [7:0] r);
    bit tick, set_i, set_o, nr;
    int nm, nc, np, nf;
    tick = (m_mode == 1 || m_mode == 2) && (m_phase == TICK_DIV - 1);
    nm = m_mode; nc = m_count; np = m_phase; nf = m_fire_left; nr = m_rreq;
    set_i = 0; set_o = 0;
    if (m_mode == 3) begin
      if (m_fire_left == 1) begin nm = 0; nr = 0; end
      else nf = m_fire_left - 1;
    end else if (m_pend) begin
      np = 0;
      if (r[7]) begin nm = 1; nc = (r[5:0] == 6'd0) ? 64 : int'(r[5:0]); end
      else begin nm = 0; nc = 0; end
    end else if (m_mode != 0 && !r[7]) begin
      nm = 0; nc = 0; np = 0;
    end else if (tick && m_count == 1) begin
      nm = 3; nc = 0; np = 0; nr = 1; nf = RST_PULSE; set_o = 1;
    end else if (m_mode != 0) begin
      np = (m_phase + 1) % TICK_DIV;
      if (tick) nc = m_count - 1;
      if (m_mode == 1 && r[6] && m_count <= PRE_TICKS) begin nm = 2; set_i = 1; end
    end
    m_ireq = set_i ? 1'b1 : (ci ? 1'b0 : m_ireq);
    m_occ  = set_o ? 1'b1 : (co ? 1'b0 : m_occ);
    m_mode = nm; m_count = nc; m_phase = np; m_fire_left = nf; m_rreq = nr;
    m_pend = ld;
  endtask

  task automatic compare_model();
    check("state", 32'(WDState), 32'(m_mode));
    check("count", 32'(WDCount), 32'(m_count));
    check("ireq", 32'(WatchDogIREQ), 32'(m_ireq));
    check("occurred", 32'(WatchDogOccurred), 32'(m_occ));
    check("rst_req", 32'(WDResetReq), 32'(m_rreq));
  endtask

  task automatic step(input bit ld, input bit ci, input bit co);
    LoadWDTimer = ld; ClrWDIreq = ci; ClrWDOccurred = co;
    @(posedge LpcClock);
    model_edge(ld, ci, co, wd_reg);
    #1;
    LoadWDTimer = 1'b0; ClrWDIreq = 1'b0; ClrWDOccurred = 1'b0;
    compare_model();
  endtask

  task automatic wait_state(input int st, input int bound);
    for (int i = 0; i < bound && WDState != 2'(st); i++) step(0, 0, 0);
  endtask

  initial begin
    int n, hi, min_cnt;
    bit ld, ci, co;
    model_reset();
    #12;
    check("rst_state", 32'(WDState), 0);
    check("rst_count", 32'(WDCount), 0);
    check("rst_ireq", 32'(WatchDogIREQ), 0);
    check("rst_occ", 32'(WatchDogOccurred), 0);
    check("rst_req", 32'(WDResetReq), 0);
    @(negedge LpcClock);
    PciReset = 1'b1;
    step(0, 0, 0);

    // 1: full run with pre-timeout and fire
    wd_reg = 8'hC5;
    step(1, 0, 0);
    step(0, 0, 0);
    check("t1_load_count", 32'(WDCount), 5);
    check("t1_load_state", 32'(WDState), 1);
    wait_state(2, 200);
    check("t1_pre_state", 32'(WDState), 2);
    check("t1_pre_count", 32'(WDCount), 2);
    check("t1_pre_ireq", 32'(WatchDogIREQ), 1);
    for (int i = 0; i < 200 && !WDResetReq; i++) step(0, 0, 0);
    check("t1_fire_state", 32'(WDState), 3);
    check("t1_fire_occ", 32'(WatchDogOccurred), 1);
    check("t1_fire_count", 32'(WDCount), 0);
    hi = 1;
    for (int i = 0; i < 50 && WDResetReq; i++) begin
      step(0, 0, 0);
      if (WDResetReq) hi++;
    end
    check("t1_pulse_width", 32'(hi), RST_PULSE);
    check("t1_after_state", 32'(WDState), 0);
    $display("test1 pre-timeout and fire: pulse width %0d", hi);

    // 2: no IntEnable, expiry after 5 ticks of prescaling
    step(0, 1, 1);
    wd_reg = 8'h85;
    step(1, 0, 0);
    step(0, 0, 0);
    n = 0;
    for (int i = 0; i < 200 && WDState != 2'd3; i++) begin step(0, 0, 0); n++; end
    check("t2_cycles_to_fire", 32'(n), 5 * TICK_DIV);
    check("t2_ireq", 32'(WatchDogIREQ), 0);
    check("t2_occ", 32'(WatchDogOccurred), 1);
    wait_state(0, 50);
    $display("test2 no-int expiry after %0d cycles", n);

    // 3: periodic reload keeps the count from running down
    step(0, 1, 1);
    wd_reg = 8'hC5;
    step(1, 0, 0);
    min_cnt = 64;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 11; j++) begin
        step(0, 0, 0);
        if (int'(WDCount) < min_cnt) min_cnt = int'(WDCount);
      end
      step(1, 0, 0);
      if (int'(WDCount) < min_cnt) min_cnt = int'(WDCount);
    end
    check("t3_min_count", 32'(min_cnt), 3);
    check("t3_ireq", 32'(WatchDogIREQ), 0);
    check("t3_occ", 32'(WatchDogOccurred), 0);
    check("t3_state", 32'(WDState), 1);
    $display("test3 periodic reload: min count %0d", min_cnt);

    // 4: zero timeout means 64, then disable mid-run
    wd_reg = 8'h80;
    step(1, 0, 0);
    step(0, 0, 0);
    check("t4_count64", 32'(WDCount), 64);
    repeat (10) step(0, 0, 0);
    wd_reg = 8'h00;
    step(0, 0, 0);
    check("t4_dis_state", 32'(WDState), 0);
    check("t4_dis_count", 32'(WDCount), 0);
    check("t4_dis_occ", 32'(WatchDogOccurred), 0);
    $display("test4 count 64 and disable");

    // 5: set wins over a coincident clear
    wd_reg = 8'hC2;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("t5_ireq_set_wins", 32'(WatchDogIREQ), 1);
    check("t5_pre_state", 32'(WDState), 2);
    step(0, 1, 0);
    check("t5_ireq_cleared", 32'(WatchDogIREQ), 0);
    wd_reg = 8'h81;
    step(1, 0, 0);
    step(0, 0, 0);
    check("t5_reload_run", 32'(WDState), 1);
    repeat (TICK_DIV - 1) step(0, 0, 0);
    step(0, 0, 1);
    check("t5_fire_state", 32'(WDState), 3);
    check("t5_occ_set_wins", 32'(WatchDogOccurred), 1);
    step(0, 0, 1);
    check("t5_occ_cleared", 32'(WatchDogOccurred), 0);
    wait_state(0, 50);
    $display("test5 set-over-clear priority");

    // 6: asynchronous reset during the reset pulse
    wd_reg = 8'h81;
    step(1, 0, 0);
    step(0, 0, 0);
    wait_state(3, 50);
    check("t6_in_fire", 32'(WDResetReq), 1);
    PciReset = 1'b0;
    #1;
    model_reset();
    check("t6_rst_state", 32'(WDState), 0);
    check("t6_rst_req", 32'(WDResetReq), 0);
    check("t6_rst_occ", 32'(WatchDogOccurred), 0);
    check("t6_rst_count", 32'(WDCount), 0);
    @(negedge LpcClock);
    @(negedge LpcClock);
    PciReset = 1'b1;
    repeat (8) step(0, 0, 0);
    check("t6_idle_after", 32'(WDState), 0);
    $display("test6 async reset during fire");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0)
        wd_reg = {($urandom_range(0, 7) != 0), 1'($urandom), 6'($urandom_range(0, 8))};
      ld = ($urandom_range(0, 15) == 0);
      ci = ($urandom_range(0, 19) == 0);
      co = ($urandom_range(0, 19) == 0);
      step(ld, ci, co);
    end
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
